psum_out_router: RTL



---
 rtl/psum_out_router_pkg.sv | 26 ++
 rtl/psum_out_router_sync_fifo.sv | 78 +++++++
 rtl/psum_out_router.sv | 133 +++++++++++++
 3 files changed

// File: rtl/psum_out_router_pkg.sv
// Shared constants and route encodings for the per-column psum egress router.
// Provides the default word/counter widths, the default FIFO depth and the
// route selection enum together with small decode helpers.
package psum_out_router_pkg;

    localparam int unsigned HWC_PSUM_BUFFER_WIDTH      = 16;
    localparam int unsigned HWC_SIMD                   = 4;
    localparam int unsigned HWC_MAX_CONFIG_WIDTH       = 16;
    localparam int unsigned HWC_PSUM_ROUTER_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        PSUM_ROUTE_GLB  = 2'b00,
        PSUM_ROUTE_NBR  = 2'b01,
        PSUM_ROUTE_BOTH = 2'b10,
        PSUM_ROUTE_DROP = 2'b11
    } psum_route_e;

    function automatic logic route_has_glb(input psum_route_e r);
        return (r == PSUM_ROUTE_GLB) || (r == PSUM_ROUTE_BOTH);
    endfunction

    function automatic logic route_has_nbr(input psum_route_e r);
        return (r == PSUM_ROUTE_NBR) || (r == PSUM_ROUTE_BOTH);
    endfunction

endpackage

// File: rtl/psum_out_router_sync_fifo.sv
// Small synchronous FIFO with a synchronous flush.
// Ports: clk/rstn (sync active-low reset), flush (drop all entries),
// push/push_data (write, ignored when full), pop (read, ignored when empty),
// full/empty (from the registered count), head (oldest entry).
module psum_out_router_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the router masks head while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/psum_out_router.sv
// Per-column partial-sum egress router.
// Buffers packed psum words from the cluster column and forwards the FIFO head
// to the GLB, the neighbour router, both, or drops it. Counts delivered words
// and pulses block_done one cycle after the last pop of each block.
// Ports: clk/rstn; conf_en/conf_rst/route_config/block_len (configuration);
// psum_in_* (cluster-side valid/ready input); glb_* and nbr_* (destination
// valid/ready outputs sharing the FIFO head as data); block_done.
module psum_out_router
    import psum_out_router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = HWC_PSUM_BUFFER_WIDTH * HWC_SIMD,
    parameter int unsigned FIFO_DEPTH = HWC_PSUM_ROUTER_FIFO_DEPTH,
    parameter int unsigned CNT_WIDTH  = HWC_MAX_CONFIG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  conf_en,
    input  logic                  conf_rst,
    input  logic [1:0]            route_config,
    input  logic [CNT_WIDTH-1:0]  block_len,
    input  logic [DATA_WIDTH-1:0] psum_in_data,
    input  logic                  psum_in_valid,
    output logic                  psum_in_ready,
    output logic [DATA_WIDTH-1:0] glb_data,
    output logic                  glb_valid,
    input  logic                  glb_ready,
    output logic [DATA_WIDTH-1:0] nbr_data,
    output logic                  nbr_valid,
    input  logic                  nbr_ready,
    output logic                  block_done
);

    psum_route_e           route_q, route_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  sent_glb_q, sent_glb_d;
    logic                  sent_nbr_q, sent_nbr_d;
    logic                  done_q, done_d;

    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  sel_glb, sel_nbr, glb_hs, nbr_hs, glb_sat, nbr_sat;

    // Ready comes from the registered count only, so a same-cycle pop never
    // reopens a full FIFO.
    assign psum_in_ready = rstn & ~fifo_full;
    assign fifo_push     = psum_in_valid & psum_in_ready;

    psum_out_router_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (conf_rst),
        .push      (fifo_push),
        .push_data (psum_in_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign glb_data   = fifo_empty ? '0 : fifo_head;
    assign nbr_data   = fifo_empty ? '0 : fifo_head;
    assign block_done = done_q;

    always_comb begin
        sel_glb   = route_has_glb(route_q);
        sel_nbr   = route_has_nbr(route_q);
        glb_valid = ~fifo_empty & sel_glb & ~sent_glb_q;
        nbr_valid = ~fifo_empty & sel_nbr & ~sent_nbr_q;
        glb_hs    = glb_valid & glb_ready;
        nbr_hs    = nbr_valid & nbr_ready;
        // An unselected destination is always satisfied, so the drop route
        // pops every non-empty cycle without any valid.
        glb_sat   = ~sel_glb | sent_glb_q | glb_hs;
        nbr_sat   = ~sel_nbr | sent_nbr_q | nbr_hs;
        fifo_pop  = ~fifo_empty & glb_sat & nbr_sat;

        route_d    = route_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        sent_glb_d = sent_glb_q;
        sent_nbr_d = sent_nbr_q;
        done_d     = 1'b0;

        if (conf_rst) begin
            route_d    = PSUM_ROUTE_GLB;
            len_d      = '0;
            cnt_d      = '0;
            sent_glb_d = 1'b0;
            sent_nbr_d = 1'b0;
        end else begin
            if (fifo_pop) begin
                sent_glb_d = 1'b0;
                sent_nbr_d = 1'b0;
                if ((len_q != '0) && (cnt_q == len_q - CNT_WIDTH'(1))) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end else begin
                if (glb_hs) sent_glb_d = 1'b1;
                if (nbr_hs) sent_nbr_d = 1'b1;
            end
            if (conf_en && fifo_empty && !sent_glb_q && !sent_nbr_q) begin
                route_d = psum_route_e'(route_config);
                len_d   = block_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            route_q    <= PSUM_ROUTE_GLB;
            len_q      <= '0;
            cnt_q      <= '0;
            sent_glb_q <= 1'b0;
            sent_nbr_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            route_q    <= route_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            sent_glb_q <= sent_glb_d;
            sent_nbr_q <= sent_nbr_d;
            done_q     <= done_d;
        end
    end

endmodule
